sobel_uart_framer: RTL and testbench

SOBEL_UART_FRAMER -- requirements
Module: sobel_uart_framer

---
 rtl/sobel_uart_framer.sv | 151 +++++++++++++++
 tb/tb_sobel_uart_framer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_uart_framer.sv
// Sobel-to-UART packet framer.
// Buffers {sof, pixel} pairs in a small FIFO and serialises each frame as
// AA 55 LEN_H LEN_L <payload> XOR-checksum, paced by a UART transmitter
// that reports idle on tx_ready and takes a one-cycle tx_valid start pulse.
module sobel_uart_framer #(
    parameter int FRAME_PIXELS = 4800,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pix_data,
    input  logic        pix_sof,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] drop_count
);

    localparam int          AW  = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LEN = 16'(FRAME_PIXELS);

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, LEN_H, LEN_L, PAYLOAD, CSUM
    } state_t;

    state_t state, state_next;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_full, fifo_empty, wr_en, pop;
    logic [8:0]  head;

    // Datapath control produced by the FSM
    logic        issue, csum_clr, drop_inc, done_next, send_ok;
    logic [7:0]  issue_byte;
    logic [7:0]  csum;
    logic [15:0] byte_cnt;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pix_ready  = !fifo_full;
    assign wr_en      = pix_valid && pix_ready;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign send_ok    = tx_ready && !tx_valid;
    assign busy       = (state != IDLE);

    // FIFO storage write port
    // NOTE: the storage array has no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {pix_sof, pix_data};
    end

    // FIFO pointers; write and pop may happen in the same cycle
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state and per-cycle datapath controls
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue      = 1'b0;
        issue_byte = tx_data;
        csum_clr   = 1'b0;
        drop_inc   = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head[8]) begin
                        state_next = HDR0;
                        csum_clr   = 1'b1;
                    end else begin
                        pop      = 1'b1;
                        drop_inc = 1'b1;
                    end
                end
            end
            HDR0: if (send_ok) begin
                issue = 1'b1; issue_byte = 8'hAA; state_next = HDR1;
            end
            HDR1: if (send_ok) begin
                issue = 1'b1; issue_byte = 8'h55; state_next = LEN_H;
            end
            LEN_H: if (send_ok) begin
                issue = 1'b1; issue_byte = LEN[15:8]; state_next = LEN_L;
            end
            LEN_L: if (send_ok) begin
                issue = 1'b1; issue_byte = LEN[7:0]; state_next = PAYLOAD;
            end
            PAYLOAD: if (send_ok && !fifo_empty) begin
                issue      = 1'b1;
                issue_byte = head[7:0];
                pop        = 1'b1;
                if (byte_cnt == LEN - 16'd1) state_next = CSUM;
            end
            CSUM: if (send_ok) begin
                issue      = 1'b1;
                issue_byte = csum;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output byte register, pulse generation, checksum and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            frame_done <= 1'b0;
            csum       <= 8'h00;
            byte_cnt   <= 16'd0;
            drop_count <= 16'd0;
        end else begin
            tx_valid   <= issue;
            frame_done <= done_next;
            if (issue) tx_data <= issue_byte;
            if (csum_clr) begin
                csum     <= 8'h00;
                byte_cnt <= 16'd0;
            end else if (issue && state == PAYLOAD) begin
                csum     <= csum ^ issue_byte;
                byte_cnt <= byte_cnt + 16'd1;
            end
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_sobel_uart_framer.sv
// Testbench for sobel_uart_framer: a behavioural UART transmitter at 4 clocks
// per bit drives tx_ready, a line decoder recovers the serial bytes, and two
// scoreboard queues hold the expected byte stream at tx_valid and on the line.
module tb_sobel_uart_framer;

    localparam int FP    = 4;
    localparam int DEPTH = 16;

    typedef logic [7:0] frame_t [FP];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pix_data;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic [15:0] drop_count;

    sobel_uart_framer #(.FRAME_PIXELS(FP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboards: bytes expected at tx_valid and bytes expected on the serial line
    logic [7:0] exp_q[$];
    logic [7:0] ser_q[$];
    logic       check_ser = 1'b1;
    int         tx_pulses = 0;
    int         frames    = 0;
    int         ser_dec   = 0;
    int         acc_cnt   = 0;

    // Behavioural UART transmitter: 10 bits, 4 clocks each
    logic       hold   = 1'b0;
    logic       ubusy  = 1'b0;
    logic [9:0] shreg  = 10'h3FF;
    int         clkcnt = 0;
    int         bitcnt = 0;
    logic       line;

    assign line     = ubusy ? shreg[0] : 1'b1;
    assign tx_ready = !ubusy && !hold;

    always @(posedge clk) begin
        if (!ubusy) begin
            if (tx_valid) begin
                shreg  <= {1'b1, tx_data, 1'b0};
                ubusy  <= 1'b1;
                clkcnt <= 0;
                bitcnt <= 0;
            end
        end else if (clkcnt == 3) begin
            clkcnt <= 0;
            shreg  <= {1'b1, shreg[9:1]};
            bitcnt <= bitcnt + 1;
            if (bitcnt == 9) ubusy <= 1'b0;
        end else begin
            clkcnt <= clkcnt + 1;
        end
    end

    // Serial line decoder, sampling mid-bit
    logic       rx_busy = 1'b0;
    int         tmr     = 0;
    int         rx_bit  = 0;
    logic [7:0] rx_sh   = 8'h00;

    always @(posedge clk) begin
        if (!rx_busy) begin
            if (!line) begin
                rx_busy <= 1'b1;
                tmr     <= 5;
                rx_bit  <= 0;
            end
        end else if (tmr != 0) begin
            tmr <= tmr - 1;
        end else if (rx_bit < 8) begin
            rx_sh  <= {line, rx_sh[7:1]};
            rx_bit <= rx_bit + 1;
            tmr    <= 3;
        end else begin
            rx_busy <= 1'b0;
            if (check_ser) begin
                ser_dec++;
                check("ser_stop", 16'(line), 16'd1);
                check("ser_avail", 16'(ser_q.size() > 0), 16'd1);
                if (ser_q.size() > 0) check("ser_byte", 16'(rx_sh), 16'(ser_q.pop_front()));
            end
        end
    end

    // Monitor of the tx handshake, sampled on the falling edge
    logic       prev_valid = 1'b0;
    logic       prev_rst   = 1'b0;
    logic [7:0] last_data  = 8'h00;

    always @(negedge clk) begin
        if (rst_n && prev_rst) begin
            if (tx_valid) begin
                tx_pulses++;
                check("tx_not_back_to_back", 16'(prev_valid), 16'd0);
                check("tx_ready_at_pulse", 16'(tx_ready), 16'd1);
                check("tx_avail", 16'(exp_q.size() > 0), 16'd1);
                if (exp_q.size() > 0) check("tx_byte", 16'(tx_data), 16'(exp_q.pop_front()));
            end else if (tx_data !== last_data) begin
                check("tx_data_stable", 16'(tx_data), 16'(last_data));
            end
            if (frame_done) frames++;
        end
        prev_valid = tx_valid;
        prev_rst   = rst_n;
        last_data  = tx_data;
    end

    task automatic push_pix(input logic [7:0] d, input logic sof);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        pix_data  = d;
        pix_sof   = sof;
        pix_valid = 1'b1;
        for (int n = 0; n < 3000 && !acc; n++) begin
            acc = pix_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        #1 pix_valid = 1'b0;
        if (acc) acc_cnt++;
        else check("pix_accept", 16'(acc), 16'd1);
    endtask

    task automatic expect_frame(input frame_t px);
        logic [7:0] x;
        logic [7:0] b [$];
        x = 8'h00;
        b = '{8'hAA, 8'h55, 8'(FP >> 8), 8'(FP)};
        for (int i = 0; i < FP; i++) begin
            b.push_back(px[i]);
            x = x ^ px[i];
        end
        b.push_back(x);
        foreach (b[i]) begin
            exp_q.push_back(b[i]);
            ser_q.push_back(b[i]);
        end
    endtask

    task automatic send_frame(input frame_t px, input int gap);
        expect_frame(px);
        for (int i = 0; i < FP; i++) begin
            push_pix(px[i], i == 0);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (n < 6000 && (exp_q.size() != 0 || ser_q.size() != 0 || ubusy || rx_busy || busy)) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("drain_exp_q", 16'(exp_q.size()), 16'd0);
        check("drain_ser_q", 16'(ser_q.size()), 16'd0);
        check("idle_busy", 16'(busy), 16'd0);
    endtask

    frame_t f;
    int     base;

    initial begin
        rst_n     = 1'b0;
        pix_data  = 8'h00;
        pix_sof   = 1'b0;
        pix_valid = 1'b0;
        #1;
        check("rst_tx_valid", 16'(tx_valid), 16'd0);
        check("rst_tx_data", 16'(tx_data), 16'h00);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_frame_done", 16'(frame_done), 16'd0);
        check("rst_drop_count", drop_count, 16'd0);
        check("rst_pix_ready", 16'(pix_ready), 16'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame: AA 55 00 04 01 02 04 08 0F
        f = '{8'h01, 8'h02, 8'h04, 8'h08};
        send_frame(f, 0);
        wait_drain();
        check("basic_frames", 16'(frames), 16'd1);
        check("basic_drop", drop_count, 16'd0);

        // Three non-SOF pixels are hunted away before a valid frame
        for (int i = 0; i < 3; i++) push_pix(8'hE0 + 8'(i), 1'b0);
        send_frame(f, 0);
        wait_drain();
        check("drop_count", drop_count, 16'd3);
        check("drop_frames", 16'(frames), 16'd2);

        // Transmitter held busy while 20 pixels (five frames) are offered
        hold    = 1'b1;
        acc_cnt = 0;
        base    = tx_pulses;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < FP; i++) f[i] = 8'((k * FP + i) * 7 + 3);
            expect_frame(f);
        end
        fork
            for (int i = 0; i < 20; i++) push_pix(8'(i * 7 + 3), (i % FP) == 0);
        join_none
        repeat (200) @(negedge clk);
        check("hold_accepted", 16'(acc_cnt), 16'(DEPTH));
        check("hold_pix_ready", 16'(pix_ready), 16'd0);
        check("hold_no_tx", 16'(tx_pulses - base), 16'd0);
        check("hold_busy", 16'(busy), 16'd1);
        hold = 1'b0;
        for (int n = 0; n < 6000 && acc_cnt < 20; n++) @(negedge clk);
        check("hold_all_accepted", 16'(acc_cnt), 16'd20);
        wait_drain();
        check("hold_frames", 16'(frames), 16'd7);

        // Source gaps longer than a UART byte: FIFO empties mid-payload
        f = '{8'h3C, 8'hC3, 8'h5A, 8'hFF};
        send_frame(f, 60);
        wait_drain();
        check("gap_frames", 16'(frames), 16'd8);

        // Two back-to-back frames checked on the decoded serial stream
        base = ser_dec;
        f = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(f, 0);
        f = '{8'h80, 8'h40, 8'hA5, 8'h00};
        send_frame(f, 0);
        wait_drain();
        check("b2b_serial_bytes", 16'(ser_dec - base), 16'd18);
        check("b2b_frames", 16'(frames), 16'd10);
        check("b2b_drop", drop_count, 16'd3);

        // Reset while payload byte 2 is on the line
        base = tx_pulses;
        f = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        send_frame(f, 0);
        for (int n = 0; n < 3000 && tx_pulses < base + 6; n++) @(negedge clk);
        check("rst_mid_reached", 16'(tx_pulses - base), 16'd6);
        repeat (10) @(negedge clk);
        check_ser = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_tx_valid", 16'(tx_valid), 16'd0);
        check("mid_rst_tx_data", 16'(tx_data), 16'h00);
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_frame_done", 16'(frame_done), 16'd0);
        check("mid_rst_drop_count", drop_count, 16'd0);
        check("mid_rst_pix_ready", 16'(pix_ready), 16'd1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 200 && (ubusy || rx_busy); n++) @(negedge clk);
        ser_q.delete();
        check_ser = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 16'(busy), 16'd0);
        base = frames;
        f = '{8'h01, 8'h02, 8'h04, 8'h08};
        send_frame(f, 0);
        wait_drain();
        check("post_rst_frames", 16'(frames - base), 16'd1);
        check("post_rst_drop", drop_count, 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
